// File: rtl/sfq_drv_pkg.sv
// Shared types and constants for the SFQ toggle-coded XOR stimulus driver.
package sfq_drv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EMIT_A,
      S_GAP_AB,
      S_EMIT_B,
      S_WAIT_CLK,
      S_EMIT_CLK,
      S_RECOVER
   } drv_state_e;

   localparam int DATA_TO_CLK_MIN = 1;
   localparam int AB_GAP_MIN      = 1;
   localparam int CLK_TO_DATA_MIN = 1;

   localparam int unsigned PULSE_CNT_W = 16;
   localparam int unsigned DLY_CNT_W   = 16;

endpackage

// File: rtl/sfq_toggle_out.sv
// Single toggle-coded pulse flop: every enabled cycle flips the line once.
module sfq_toggle_out (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic q_o
);

   logic q_q;

   // Flip the line on each enabled edge; reset forces it low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= 1'b0;
      else if (en_i) q_q <= ~q_q;
   end

   assign q_o = q_q;

endmodule

// File: rtl/sfq_xort_driver.sv
// Operand-pair to toggle-coded SFQ pulse transmitter (a_t, b_t, clk_t).
// Optional expected-XOR tracking on exp_q is built when SFQ_DRV_EXPECT_EN is defined.
module sfq_xort_driver
   import sfq_drv_pkg::*;
#(
   parameter int DATA_TO_CLK = 3,
   parameter int AB_GAP      = 2,
   parameter int CLK_TO_DATA = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_a,
   input  logic                   in_b,
   output logic                   in_ready,
   output logic                   a_t,
   output logic                   b_t,
   output logic                   clk_t,
   output logic                   busy,
   output logic                   exp_q,
   output logic [PULSE_CNT_W-1:0] pulse_cnt
);

   if (DATA_TO_CLK < DATA_TO_CLK_MIN) begin : g_bad_d2c
      $error("DATA_TO_CLK below minimum");
   end
   if (AB_GAP < AB_GAP_MIN) begin : g_bad_ab
      $error("AB_GAP below minimum");
   end
   if (CLK_TO_DATA < CLK_TO_DATA_MIN) begin : g_bad_c2d
      $error("CLK_TO_DATA below minimum");
   end

   localparam logic [DLY_CNT_W-1:0] AB_LOAD  = DLY_CNT_W'(AB_GAP - 1);
   localparam logic [DLY_CNT_W-1:0] D2C_LOAD = DLY_CNT_W'(DATA_TO_CLK - 1);
   localparam logic [DLY_CNT_W-1:0] C2D_LOAD = DLY_CNT_W'(CLK_TO_DATA - 1);

   drv_state_e             state_q, state_d;
   logic [DLY_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   op_a_q, op_b_q;
   logic [PULSE_CNT_W-1:0] pulse_cnt_q;
   logic                   a_en, b_en, c_en;
   logic                   xfer;

   assign xfer     = in_valid && (state_q == S_IDLE);
   assign in_ready = (state_q == S_IDLE);
   assign busy     = !in_ready;

   // State, shared delay counter, operand capture and pulse counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_a_q      <= 1'b0;
         op_b_q      <= 1'b0;
         pulse_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (xfer) begin
            op_a_q <= in_a;
            op_b_q <= in_b;
         end
         if (c_en) pulse_cnt_q <= pulse_cnt_q + 1'b1;
      end
   end

   // Sequencing: one-cycle gap is skipped entirely when a spacing parameter is 1,
   // so the delay states only ever run for (param - 1) cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_en    = 1'b0;
      b_en    = 1'b0;
      c_en    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) state_d = S_EMIT_A;
         end
         S_EMIT_A: begin
            a_en = op_a_q;
            if (op_a_q && op_b_q) begin
               if (AB_GAP > 1) begin
                  state_d = S_GAP_AB;
                  cnt_d   = AB_LOAD;
               end else begin
                  state_d = S_EMIT_B;
               end
            end else begin
               b_en = op_b_q;
               if (DATA_TO_CLK > 1) begin
                  state_d = S_WAIT_CLK;
                  cnt_d   = D2C_LOAD;
               end else begin
                  state_d = S_EMIT_CLK;
               end
            end
         end
         S_GAP_AB: begin
            if (cnt_q <= 1) state_d = S_EMIT_B;
            else cnt_d = cnt_q - 1'b1;
         end
         S_EMIT_B: begin
            b_en = 1'b1;
            if (DATA_TO_CLK > 1) begin
               state_d = S_WAIT_CLK;
               cnt_d   = D2C_LOAD;
            end else begin
               state_d = S_EMIT_CLK;
            end
         end
         S_WAIT_CLK: begin
            if (cnt_q <= 1) state_d = S_EMIT_CLK;
            else cnt_d = cnt_q - 1'b1;
         end
         S_EMIT_CLK: begin
            c_en = 1'b1;
            if (CLK_TO_DATA > 1) begin
               state_d = S_RECOVER;
               cnt_d   = C2D_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RECOVER: begin
            if (cnt_q <= 1) state_d = S_IDLE;
            else cnt_d = cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   sfq_toggle_out u_a_t   (.clk(clk), .rst(rst), .en_i(a_en), .q_o(a_t));
   sfq_toggle_out u_b_t   (.clk(clk), .rst(rst), .en_i(b_en), .q_o(b_t));
   sfq_toggle_out u_clk_t (.clk(clk), .rst(rst), .en_i(c_en), .q_o(clk_t));

`ifdef SFQ_DRV_EXPECT_EN
   logic e_en;
   assign e_en = c_en && (op_a_q ^ op_b_q);
   sfq_toggle_out u_exp_q (.clk(clk), .rst(rst), .en_i(e_en), .q_o(exp_q));
`else
   assign exp_q = 1'b0;
`endif

   assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_sfq_xort_driver.sv
// Self-checking bench for sfq_xort_driver: edge-schedule reference model plus directed literals.
module tb_sfq_xort_driver;

   localparam int AB  = 2;
   localparam int D2C = 3;
   localparam int C2D = 2;
   localparam int HN  = 8192;
`ifdef SFQ_DRV_EXPECT_EN
   localparam logic EXP_ON = 1'b1;
`else
   localparam logic EXP_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_a, in_b;
   logic        in_ready, a_t, b_t, clk_t, busy, exp_q;
   logic [15:0] pulse_cnt;

   sfq_xort_driver #(.DATA_TO_CLK(D2C), .AB_GAP(AB), .CLK_TO_DATA(C2D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .in_ready(in_ready), .a_t(a_t), .b_t(b_t), .clk_t(clk_t), .busy(busy),
      .exp_q(exp_q), .pulse_cnt(pulse_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n      = 0;

   // Model: scheduled pulse edges for the in-flight pair, plus current line levels.
   int          ta, tbe, tc, next_ok, ed;
   logic        ma, mb, mc, me, mx;
   logic [15:0] mcnt;

   logic        h_a [HN], h_b [HN], h_c [HN], h_e [HN], h_r [HN];
   logic [15:0] h_cnt [HN];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, exp);
      end
   endtask

   task automatic model_reset();
      ta = -1; tbe = -1; tc = -1; next_ok = 0;
      ma = 0; mb = 0; mc = 0; me = 0; mx = 0; mcnt = '0;
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) begin
         if (n == ta)  ma = ~ma;
         if (n == tbe) mb = ~mb;
         if (n == tc) begin
            mc = ~mc;
            mcnt++;
            if (EXP_ON && mx) me = ~me;
         end
         if (in_valid && n >= next_ok) begin
            ta = in_a ? n + 1 : -1;
            if (in_a && in_b) tbe = n + 1 + AB;
            else if (in_b)    tbe = n + 1;
            else              tbe = -1;
            ed      = in_b ? tbe : n + 1;
            tc      = ed + D2C;
            next_ok = tc + C2D;
            mx      = in_a ^ in_b;
         end
      end
      #1;
      chk("a_t", 16'(a_t), 16'(ma));
      chk("b_t", 16'(b_t), 16'(mb));
      chk("clk_t", 16'(clk_t), 16'(mc));
      chk("exp_q", 16'(exp_q), 16'(me));
      chk("pulse_cnt", pulse_cnt, mcnt);
      chk("in_ready", 16'(in_ready), 16'(n + 1 >= next_ok));
      chk("busy", 16'(busy), 16'(!(n + 1 >= next_ok)));
      if (n < HN) begin
         h_a[n] = a_t; h_b[n] = b_t; h_c[n] = clk_t; h_e[n] = exp_q;
         h_r[n] = in_ready; h_cnt[n] = pulse_cnt;
      end
      n++;
   endtask

   // Asynchronous reset asserted mid-cycle, held across one edge, released mid-cycle.
   task automatic do_reset();
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("rst_a_t", 16'(a_t), 16'd0);
      chk("rst_b_t", 16'(b_t), 16'd0);
      chk("rst_clk_t", 16'(clk_t), 16'd0);
      chk("rst_exp_q", 16'(exp_q), 16'd0);
      chk("rst_pulse_cnt", pulse_cnt, 16'd0);
      in_valid = 1'b0;
      step();
      #2 rst = 1'b0;
   endtask

   task automatic send(input logic a, input logic b);
      in_valid = 1'b1; in_a = a; in_b = b;
   endtask

   int t0, t1;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
      model_reset();
      step(); step();
      #2 rst = 1'b0;
      step();
      chk("lit_ready_after_rst", 16'(h_r[n-1]), 16'd1);
      chk("lit_cnt_after_rst", h_cnt[n-1], 16'd0);

      // (1,0)
      send(1'b1, 1'b0); t0 = n; step(); in_valid = 1'b0;
      repeat (9) step();
      chk("lit10_a0", 16'(h_a[t0]), 16'd0);
      chk("lit10_a1", 16'(h_a[t0+1]), 16'd1);
      chk("lit10_b", 16'(h_b[t0+9]), 16'd0);
      chk("lit10_c3", 16'(h_c[t0+3]), 16'd0);
      chk("lit10_c4", 16'(h_c[t0+4]), 16'd1);
      chk("lit10_e4", 16'(h_e[t0+4]), 16'(EXP_ON));
      chk("lit10_cnt4", h_cnt[t0+4], 16'd1);
      chk("lit10_r4", 16'(h_r[t0+4]), 16'd0);
      chk("lit10_r5", 16'(h_r[t0+5]), 16'd1);

      // (1,1)
      do_reset();
      send(1'b1, 1'b1); t0 = n; step(); in_valid = 1'b0;
      repeat (9) step();
      chk("lit11_a1", 16'(h_a[t0+1]), 16'd1);
      chk("lit11_b2", 16'(h_b[t0+2]), 16'd0);
      chk("lit11_b3", 16'(h_b[t0+3]), 16'd1);
      chk("lit11_c5", 16'(h_c[t0+5]), 16'd0);
      chk("lit11_c6", 16'(h_c[t0+6]), 16'd1);
      chk("lit11_e6", 16'(h_e[t0+6]), 16'd0);
      chk("lit11_r6", 16'(h_r[t0+6]), 16'd0);
      chk("lit11_r7", 16'(h_r[t0+7]), 16'd1);

      // (0,0) then (0,1) with valid held high
      do_reset();
      send(1'b0, 1'b0); t0 = n; step();
      send(1'b0, 1'b1);
      repeat (6) step();
      in_valid = 1'b0;
      repeat (5) step();
      chk("lit0001_c4", 16'(h_c[t0+4]), 16'd1);
      chk("lit0001_r5", 16'(h_r[t0+5]), 16'd1);
      chk("lit0001_b6", 16'(h_b[t0+6]), 16'd0);
      chk("lit0001_b7", 16'(h_b[t0+7]), 16'd1);
      chk("lit0001_c9", 16'(h_c[t0+9]), 16'd1);
      chk("lit0001_c10", 16'(h_c[t0+10]), 16'd0);
      chk("lit0001_cnt", h_cnt[t0+10], 16'd2);
      chk("lit0001_e", 16'(h_e[t0+10]), 16'(EXP_ON));

      // Reset between a pulse and clock pulse of a (1,0) pair
      do_reset();
      send(1'b1, 1'b0); t0 = n; step(); in_valid = 1'b0;
      step(); step();
      do_reset();
      repeat (6) step();
      chk("litabort_c", 16'(h_c[t0+7]), 16'd0);
      chk("litabort_a", 16'(h_a[t0+7]), 16'd0);
      chk("litabort_cnt", h_cnt[t0+7], 16'd0);
      send(1'b1, 1'b0); t1 = n; step(); in_valid = 1'b0;
      repeat (6) step();
      chk("litfresh_a1", 16'(h_a[t1+1]), 16'd1);
      chk("litfresh_c4", 16'(h_c[t1+4]), 16'd1);
      chk("litfresh_cnt4", h_cnt[t1+4], 16'd1);

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 2500; i++) begin
         in_valid = ($urandom_range(0, 9) < 6);
         in_a     = 1'($urandom_range(0, 1));
         in_b     = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 499) == 0) do_reset();
         else step();
      end
      in_valid = 1'b0;
      repeat (12) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sfq_xort_driver.md
# sfq_xort_driver

Synchronous transmitter that converts a stream of 2-bit operand pairs into toggle-coded SFQ pulse streams on three wires: `a_t`, `b_t` and `clk_t`. On these wires every transition, rising or falling, is one pulse. The block sits on the stimulus side of clocked two-input toggle-output RSFQ cells such as the clocked XOR models, in mixed RTL/cell-model benches. It enforces data-before-clock, a-before-b and clock-recovery spacing, and can model the expected XOR output.

## Interface
Parameters:
- `DATA_TO_CLK`, default 3: cycles from the last data pulse to the clock pulse; minimum 1.
- `AB_GAP`, default 2: cycles between the `a_t` and `b_t` pulses when both are sent; minimum 1.
- `CLK_TO_DATA`, default 2: cycles from the clock pulse until the next operand pair may be accepted; minimum 1.

Ports:
- `clk`  in  1  system clock; rising-edge only.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_a`  in  1  send an `a` pulse.
- `in_b`  in  1  send a `b` pulse.
- `in_ready`  out  1  block can accept an operand pair.
- `a_t`  out  1  toggle-coded `a` pulse line.
- `b_t`  out  1  toggle-coded `b` pulse line.
- `clk_t`  out  1  toggle-coded SFQ clock line.
- `busy`  out  1  equals `!in_ready`.
- `exp_q`  out  1  expected toggle-coded XOR output.
- `pulse_cnt`  out  16  number of `clk_t` pulses emitted; wraps from 0xFFFF to 0.

## Operation
- Handshake: a transfer occurs at a rising edge where `in_valid && in_ready`.
  - `in_ready` is 1 only in IDLE.
  - Operands are registered on transfer.
  - Input values are don't-care when no transfer occurs.
- FSM states: IDLE, EMIT_A, GAP_AB, EMIT_B, WAIT_CLK, EMIT_CLK, RECOVER.
  - IDLE → EMIT_A on transfer.
  - EMIT_A: toggle `a_t` if `op_a`.
    - Both operands set: go to GAP_AB.
    - Otherwise: toggle `b_t` in this same cycle if `op_b`, then go to WAIT_CLK.
  - GAP_AB: count `AB_GAP-1` cycles, then EMIT_B.
  - EMIT_B: toggle `b_t`, then WAIT_CLK.
  - WAIT_CLK: count `DATA_TO_CLK-1` cycles, then EMIT_CLK.
  - EMIT_CLK: toggle `clk_t`, increment `pulse_cnt`, update `exp_q`, then RECOVER.
  - RECOVER: count `CLK_TO_DATA-1` cycles, then IDLE.
- Operand pair (0,0) emits only the clock pulse.
- The `a` pulse always precedes the `b` pulse. They never share an edge.
- All pulse outputs are registered. There is never more than one toggle per output per cycle.
- Reset values: `a_t`, `b_t`, `clk_t`, `exp_q` = 0; `pulse_cnt` = 0; `in_ready` = 1 once `rst` is low; FSM in IDLE.
- Reset mid-operation aborts the sequence immediately and applies the reset values.
  - A toggle line falling to 0 under reset is not a valid pulse.
  - Downstream cell models must be held or ignored while `rst` is high.
- Parameter values below their minimum are a compile-time error.

## Timing
- Transfer at edge T. Define the following edges:
  - E_a = T+1 for the `a` pulse, if sent.
  - E_b = T+1+AB_GAP if both operands are set; otherwise E_b = T+1 for a `b`-only pulse.
  - E_d = last data edge. This is E_b if a `b` pulse is sent, otherwise T+1.
  - E_c = E_d + DATA_TO_CLK, the `clk_t` edge.
  - Next transfer possible at edge E_c + CLK_TO_DATA.
- Occupancy with defaults:
  - single operand or (0,0): 6 cycles.
  - (1,1): 8 cycles.
- `exp_q`, `pulse_cnt` and `clk_t` all change on the same edge.

## Configuration
- `SFQ_DRV_EXPECT_EN` defined:
  - `exp_q` toggles at E_c when `op_a ^ op_b`.
  - This models a clocked toggle-output XOR fed by this block.
- Not defined: `exp_q` is constant 0 and no tracking logic is built.
- `pulse_cnt` exists in both builds.

## Structure
- Package `sfq_drv_pkg`:
  - FSM state enum.
  - Parameter minimum constants.
  - `PULSE_CNT_W` = 16.
- Sub-module `sfq_toggle_out`: a single toggle flop with enable and async reset. It is instantiated for `a_t`, `b_t` and `clk_t`, plus `exp_q` when the macro is enabled.
- One shared down-counter serves GAP_AB, WAIT_CLK and RECOVER. It is loaded on each state entry.

## Test plan
All scenarios use default parameters and are built with `SFQ_DRV_EXPECT_EN` unless stated otherwise.
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; `in_ready` = 1 after release; `pulse_cnt` = 0.
- (1,0) accepted at edge 0 → `a_t` 0→1 at edge 1; `b_t` unchanged; `clk_t` 0→1 and `exp_q` 0→1 at edge 4; `in_ready` high for edge 6.
- (1,1) at edge 0 → `a_t` toggles at edge 1, `b_t` at edge 3, `clk_t` at edge 6; `exp_q` unchanged; next transfer at edge 8.
- (0,0) then (0,1) with `in_valid` held high → first `clk_t` toggle at edge 4; second transfer at edge 6; `b_t` toggles at edge 7, `clk_t` back to 0 at edge 10; `pulse_cnt` = 2; `exp_q` = 1.
- `rst` pulse between E_a and E_c of a (1,0) transfer → no `clk_t` toggle; all outputs 0; a new transfer behaves as from fresh reset.
- Build without `SFQ_DRV_EXPECT_EN`, send (1,0) ×3 → `exp_q` stays 0; `pulse_cnt` = 3.
